nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder that processes `NIBBLES*4`-bit operands one nibble per clock. Each cycle it drives one internally instantiated 4-bit parallel adder (`paralleladdfullbyhalf`, half-adder based) with one operand nibble and the stored carry, then captures `SUM`/`COUT` back into its result and carry registers. It is the sequencing stage that both feeds and consumes the 4-bit adder, extending it to wide operands at one-adder area cost.

## Interface

Parameters:
- `NIBBLES`, default 4: operand width in nibbles. Operand width is `W = 4*NIBBLES`. Legal range is 2..16.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: request to begin an addition. Sampled on the clock edge.
- `a`, input, W: operand A. Sampled only on the accepting edge.
- `b`, input, W: operand B. Sampled only on the accepting edge.
- `cin`, input, 1: carry-in to nibble 0. Sampled only on the accepting edge.
- `busy`, output, 1: high while an addition is in progress (state RUN).
- `done`, output, 1: one-cycle pulse; `sum`/`cout` are valid from this cycle on.
- `sum`, output, W: registered result; holds the last completed result.
- `cout`, output, 1: registered carry-out of the top nibble; holds with `sum`.

## Operation

- States are IDLE, RUN and DONE. Registered internals:
  - `a_r`, `b_r`: W bits each.
  - `acc`: W bits.
  - `carry_r`: 1 bit.
  - `idx`: nibble index, `$clog2(NIBBLES)` bits.
- IDLE:
  - `start=1` latches `a`, `b` into `a_r`, `b_r` and `cin` into `carry_r`.
  - The same edge sets `idx<=0`, clears `acc` and moves to RUN.
  - `start=0` keeps the block in IDLE.
- RUN:
  - The adder is driven with `A=a_r[4*idx+:4]`, `B=b_r[4*idx+:4]`, `CIN=carry_r`.
  - Each edge writes `acc[4*idx+:4]<=SUM`, `carry_r<=COUT` and `idx<=idx+1`.
  - On the edge that processes `idx==NIBBLES-1`:
    - `sum` takes the final `acc` value, including the nibble just computed.
    - `cout` takes `COUT`.
    - The state moves to DONE.
- DONE:
  - `done=1` for this single cycle.
  - `start=1` is accepted exactly as in IDLE, giving a back-to-back addition that goes straight to RUN.
  - Otherwise the state returns to IDLE.
- `start` during RUN is ignored. No queueing; the operands in flight are unaffected.
- `sum` and `cout` change only on a completing edge or on reset. Partial results are never visible on `sum`.
- Arithmetic is unsigned: `{cout,sum} = a + b + cin`, modulo 2^(W+1). There is no overflow flag.
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `sum=0`, `cout=0`.
  - All internal registers clear.
  - An aborted operation produces no `done`.
- The adder input nibble mux uses `idx` directly. `idx` never exceeds `NIBBLES-1` in RUN and is held at 0 outside RUN.

## Timing

- Accepting edge E (start sampled high in IDLE or DONE): `busy` is high from E to E+NIBBLES.
- Nibble k is computed in the cycle following edge E+k and registered at edge E+k+1, for k = 0..NIBBLES-1.
- At edge E+NIBBLES:
  - `sum` and `cout` update.
  - `busy` falls.
  - `done` rises and stays high for exactly one cycle.
- Latency from the accepting edge to valid `sum` is NIBBLES cycles. Peak throughput is one result per NIBBLES+1 cycles; the DONE cycle doubles as the next accepting edge.
- The combinational path per cycle is the nibble mux, then the 4-bit ripple adder, then the `acc`/`carry_r` registers. There is no carry chain longer than 4 bits.
- `busy` and `done` are registered outputs (decoded from state flops) with no combinational path from `start`.
- Reset behaviour:
  - Assertion takes effect immediately, without a clock.
  - Deassertion is synchronised externally.
  - The first edge after deassertion may accept `start`.

## Test plan

Use `NIBBLES=4` for all scenarios.

- **Basic add:** `a=16'h1234`, `b=16'h4321`, `cin=0`, pulse `start` -> `done` pulses 4 cycles after the accepting edge with `sum=16'h5555`, `cout=0`; `busy` is high for exactly 4 cycles.
- **Full ripple:** `a=16'hFFFF`, `b=16'h0000`, `cin=1` -> `sum=16'h0000`, `cout=1`; the carry propagates through all 4 nibble cycles.
- **Top overflow:** `a=16'h8000`, `b=16'h8000`, `cin=0` -> `sum=16'h0000`, `cout=1`. Then `a=16'hFFFF`, `b=16'hFFFF`, `cin=1` -> `sum=16'hFFFF`, `cout=1`.
- **Busy ignore and hold:**
  - During RUN, change `a`/`b` and pulse `start` -> the result is still the originally latched sum, and there is no extra `done`.
  - After completion, `sum`/`cout` hold for 20 idle cycles.
- **Back-to-back:** hold `start=1` with a new operand pair (`16'h00FF + 16'h0001`) during the DONE cycle -> the second `done` arrives 5 cycles after the first, with `sum=16'h0100`, `cout=0`.
- **Reset mid-run:** assert `rst_n=0` asynchronously 2 cycles into RUN -> `busy`, `done`, `sum`, `cout` are immediately 0 and no `done` follows. A following `16'h0001 + 16'h0001` completes normally with `sum=16'h0002`.
- **Reference check:** random `a`/`b`/`cin` (≥1000 ops, also with `NIBBLES=2` and 8) compared against `a+b+cin`.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that feeds one 4-bit half-adder-based adder one nibble per clock.

// 4-bit ripple adder built from half-adder pairs.
module paralleladdfullbyhalf (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] SUM,
    output logic       COUT
);

    logic [4:0] c;
    logic [3:0] hs;
    logic [3:0] hc1;
    logic [3:0] hc2;

    // Each bit: first half adder on A/B, second on partial sum and incoming carry.
    always_comb begin
        c    = '0;
        hs   = '0;
        hc1  = '0;
        hc2  = '0;
        SUM  = '0;
        c[0] = CIN;
        for (int i = 0; i < 4; i++) begin
            hs[i]    = A[i] ^ B[i];
            hc1[i]   = A[i] & B[i];
            SUM[i]   = hs[i] ^ c[i];
            hc2[i]   = hs[i] & c[i];
            c[i + 1] = hc1[i] | hc2[i];
        end
        COUT = c[4];
    end

endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IW   = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic           carry_r;
    logic [IW-1:0]  idx;
    logic [IW+1:0]  base;

    logic [3:0]     add_a;
    logic [3:0]     add_b;
    logic [3:0]     add_sum;
    logic           add_cout;

    logic           accept;
    logic           last;

    assign base   = {idx, 2'b00};
    assign add_a  = a_r[base +: 4];
    assign add_b  = b_r[base +: 4];
    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (idx == LAST);

    paralleladdfullbyhalf u_add (
        .A    (add_a),
        .B    (add_b),
        .CIN  (carry_r),
        .SUM  (add_sum),
        .COUT (add_cout)
    );

    // Accumulator with the current nibble merged in, so the final sum includes it.
    always_comb begin
        acc_nxt            = acc;
        acc_nxt[base +: 4] = add_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE behaves like IDLE for accepting a new request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= cin;
                acc     <= '0;
                idx     <= '0;
            end else if (state_q == RUN) begin
                acc     <= acc_nxt;
                carry_r <= add_cout;
                if (last) begin
                    idx  <= '0;
                    sum  <= acc_nxt;
                    cout <= add_cout;
                end else begin
                    idx  <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed checks of the nibble-serial adder with NIBBLES=4, plus a random reference sweep.
module tb_nibble_serial_adder;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start high across one edge, then drop start.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge; returns edges to done and busy-high samples.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic [W-1:0] es, input logic ec);
        int cyc;
        int bc;
        start_op(av, bv, cv);
        wait_done(cyc, bc);
        check({tag, "_lat"}, 32'(cyc), 32'd4);
        check({tag, "_busycnt"}, 32'(bc), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int           cyc;
        int           bc;
        int           ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   ref_v;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_add("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_add("ovf1", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        run_add("ovf2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // start and new operands during RUN must not disturb the operation in flight
        start_op(16'h1111, 16'h2222, 1'b0);
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bc);
        check("ign_lat", 32'(cyc + 1), 32'd4);
        check("ign_sum", 32'(sum), 32'h3333);
        check("ign_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            check("hold_sum", 32'(sum), 32'h3333);
        end
        check("ign_extra_done", 32'(ndone), 32'd0);
        check("hold_cout", 32'(cout), 32'd0);

        // back-to-back: new request while in DONE
        start_op(16'h0F0F, 16'h0101, 1'b0);
        wait_done(cyc, bc);
        check("b2b_first_sum", 32'(sum), 32'h1010);
        start_op(16'h00FF, 16'h0001, 1'b0);
        check("b2b_busy_after", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        wait_done(cyc, bc);
        check("b2b_gap", 32'(cyc + 1), 32'd5);
        check("b2b_sum", 32'(sum), 32'h0100);
        check("b2b_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset two cycles into RUN
        start_op(16'h1234, 16'h1111, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        run_add("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

        // random reference sweep
        for (int i = 0; i < 1000; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            start_op(ra, rb, rc);
            wait_done(cyc, bc);
            check("rnd_lat", 32'(cyc), 32'd4);
            check("rnd_sum", 32'(sum), 32'(ref_v[W-1:0]));
            check("rnd_cout", 32'(cout), 32'(ref_v[W]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
